// File: rtl/vm_pkg.sv
// Shared types for the vending controller: coin codes, FSM states
// and the nickel-unit value of each coin.
package vm_pkg;

    localparam int COIN_W     = 2;
    localparam int COIN_TYPES = 4;
    localparam int VAL_W      = 5;

    typedef enum logic [COIN_W-1:0] {
        COIN_NICKEL  = 2'd0,
        COIN_DIME    = 2'd1,
        COIN_QUARTER = 2'd2,
        COIN_DOLLAR  = 2'd3
    } coin_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_VEND,
        S_CHANGE
    } state_e;

    function automatic logic [VAL_W-1:0] coin_value(input coin_e c);
        logic [VAL_W-1:0] v;
        v = '0;
        unique case (c)
            COIN_NICKEL:  v = 5'd1;
            COIN_DIME:    v = 5'd2;
            COIN_QUARTER: v = 5'd5;
            COIN_DOLLAR:  v = 5'd20;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vm_vend_ctrl_if.sv
// Front-end / back-end bundle of the vending controller.
// master = coin acceptor, keypad, config and hopper; slave = controller.
interface vm_vend_ctrl_if
    import vm_pkg::*;
#(
    parameter int NUM_ITEMS = 8,
    parameter int CREDIT_W  = 8,
    parameter int PRICE_W   = 6,
    parameter int STOCK_W   = 4
);
    localparam int IDX_W = $clog2(NUM_ITEMS);

    logic                coin_valid;
    logic [COIN_W-1:0]   coin_type;
    logic                sel_valid;
    logic [IDX_W-1:0]    sel_item;
    logic                cancel;
    logic                cfg_we;
    logic [IDX_W-1:0]    cfg_idx;
    logic [PRICE_W-1:0]  cfg_price;
    logic [STOCK_W-1:0]  cfg_stock;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                vend_valid;
    logic [IDX_W-1:0]    vend_item;
    logic                err_sold_out;
    logic                err_funds;
    logic                change_valid;
    coin_e               change_coin;
    logic                change_ready;
    logic                busy;

    modport master (
        output coin_valid, coin_type, sel_valid, sel_item, cancel,
        output cfg_we, cfg_idx, cfg_price, cfg_stock, change_ready,
        input  credit, coin_reject, vend_valid, vend_item,
        input  err_sold_out, err_funds, change_valid, change_coin, busy
    );

    modport slave (
        input  coin_valid, coin_type, sel_valid, sel_item, cancel,
        input  cfg_we, cfg_idx, cfg_price, cfg_stock, change_ready,
        output credit, coin_reject, vend_valid, vend_item,
        output err_sold_out, err_funds, change_valid, change_coin, busy
    );

endinterface

// File: rtl/vm_change_gen.sv
// Greedy change picker: largest coin not exceeding the credit.
// Zero credit yields a nickel code, which is never presented.
module vm_change_gen
    import vm_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit_i,
    output coin_e               coin_o
);

    always_comb begin
        coin_o = COIN_NICKEL;
        if (32'(credit_i) >= 32'd20)
            coin_o = COIN_DOLLAR;
        else if (32'(credit_i) >= 32'd5)
            coin_o = COIN_QUARTER;
        else if (32'(credit_i) >= 32'd2)
            coin_o = COIN_DIME;
    end

endmodule

// File: rtl/vm_vend_ctrl.sv
// Vending controller: credit tracking, price/stock table, vend
// decision one cycle after a registered select, greedy change return.
module vm_vend_ctrl
    import vm_pkg::*;
#(
    parameter int NUM_ITEMS = 8,
    parameter int CREDIT_W  = 8,
    parameter int PRICE_W   = 6,
    parameter int STOCK_W   = 4
) (
    input logic         clk,
    input logic         rst_n,
    vm_vend_ctrl_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_ITEMS);
    localparam logic [CREDIT_W:0] CMAX = {1'b0, {CREDIT_W{1'b1}}};

    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [PRICE_W-1:0]  price_q [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
    logic                pend_q;
    logic [IDX_W-1:0]    pend_idx_q;
    logic                coin_reject_q;
    logic                vend_valid_q;
    logic [IDX_W-1:0]    vend_item_q;
    logic                err_sold_out_q;
    logic                err_funds_q;
    logic                change_valid_q;
    coin_e               change_coin_q;

    logic                accepting;
    logic                do_cancel;
    logic                do_sel;
    logic                do_coin;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic [PRICE_W-1:0]  price_sel;
    logic [STOCK_W-1:0]  stock_sel;
    logic                sold_out;
    logic                funds_ok;
    logic [CREDIT_W-1:0] credit_rem;
    logic [CREDIT_W-1:0] pick_in;
    coin_e               pick_coin;

    // The decision cycle after a select blocks all other front-end input.
    assign accepting = (state_q == S_IDLE || state_q == S_CREDIT)
                       && !pend_q;
    assign do_cancel = accepting && bus.cancel && state_q == S_CREDIT;
    assign do_sel    = accepting && bus.sel_valid && !do_cancel;
    assign do_coin   = accepting && bus.coin_valid
                       && !do_cancel && !do_sel;

    assign coin_sum  = {1'b0, credit_q}
                     + (CREDIT_W+1)'(coin_value(coin_e'(bus.coin_type)));
    assign coin_fits = coin_sum <= CMAX;

    assign price_sel = price_q[pend_idx_q];
    assign stock_sel = stock_q[pend_idx_q];
    assign sold_out  = stock_sel == '0;
    assign funds_ok  = {1'b0, credit_q} >= (CREDIT_W+1)'(price_sel);

    assign credit_rem = credit_q
                      - CREDIT_W'(coin_value(change_coin_q));
    assign pick_in    = (state_q == S_CHANGE) ? credit_rem : credit_q;

    vm_change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change_gen (
        .credit_i (pick_in),
        .coin_o   (pick_coin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            pend_q         <= 1'b0;
            pend_idx_q     <= '0;
            coin_reject_q  <= 1'b0;
            vend_valid_q   <= 1'b0;
            vend_item_q    <= '0;
            err_sold_out_q <= 1'b0;
            err_funds_q    <= 1'b0;
            change_valid_q <= 1'b0;
            change_coin_q  <= COIN_NICKEL;
            for (int i = 0; i < NUM_ITEMS; i++) begin
                price_q[i] <= '1;
                stock_q[i] <= '0;
            end
        end else begin
            coin_reject_q  <= bus.coin_valid && !(do_coin && coin_fits);
            vend_valid_q   <= 1'b0;
            err_sold_out_q <= 1'b0;
            err_funds_q    <= 1'b0;
            unique case (state_q)
                S_IDLE, S_CREDIT: begin
                    if (pend_q) begin
                        pend_q <= 1'b0;
                        if (sold_out) begin
                            err_sold_out_q <= 1'b1;
                        end else if (!funds_ok) begin
                            err_funds_q <= 1'b1;
                        end else begin
                            credit_q <= credit_q - CREDIT_W'(price_sel);
                            stock_q[pend_idx_q] <= stock_sel - STOCK_W'(1);
                            vend_valid_q <= 1'b1;
                            vend_item_q  <= pend_idx_q;
                            state_q      <= S_VEND;
                        end
                    end else if (do_cancel) begin
                        state_q        <= S_CHANGE;
                        change_valid_q <= 1'b1;
                        change_coin_q  <= pick_coin;
                    end else if (do_sel) begin
                        pend_q     <= 1'b1;
                        pend_idx_q <= bus.sel_item;
                    end else if (do_coin && coin_fits) begin
                        credit_q <= coin_sum[CREDIT_W-1:0];
                        state_q  <= S_CREDIT;
                    end
                    if (state_q == S_IDLE && !pend_q && bus.cfg_we) begin
                        price_q[bus.cfg_idx] <= bus.cfg_price;
                        stock_q[bus.cfg_idx] <= bus.cfg_stock;
                    end
                end
                S_VEND: begin
                    if (credit_q != '0) begin
                        state_q        <= S_CHANGE;
                        change_valid_q <= 1'b1;
                        change_coin_q  <= pick_coin;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CHANGE: begin
                    if (bus.change_ready) begin
                        credit_q <= credit_rem;
                        if (credit_rem == '0) begin
                            state_q        <= S_IDLE;
                            change_valid_q <= 1'b0;
                        end else begin
                            change_coin_q <= pick_coin;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.credit       = credit_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.vend_valid   = vend_valid_q;
    assign bus.vend_item    = vend_item_q;
    assign bus.err_sold_out = err_sold_out_q;
    assign bus.err_funds    = err_funds_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_coin  = change_coin_q;
    assign bus.busy         = (state_q == S_VEND) || (state_q == S_CHANGE);

endmodule
